// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared CPU types -- stall-controller FSM states and multi-cycle opcode constants.
package pipeline_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        DRAIN   = 2'd2,
        WFI     = 2'd3
    } state_e;
    // MUL/DIV share the OP major opcode and are told apart by funct7.
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [6:0] OPC_OP_FP     = 7'b1010011;
    localparam logic [6:0] OPC_FMADD     = 7'b1000011;
endpackage

// File: rtl/stall_counter.sv
// stall_counter: 32-bit wrapping counter with enable and a synchronous load.
module stall_counter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en_i,
    input  logic        ld_i,
    input  logic [31:0] ld_val_i,
    output logic [31:0] cnt_o
);
    logic [31:0] cnt_q, cnt_d;
    always_comb cnt_d = ld_i ? ld_val_i : en_i ? cnt_q + 32'd1 : cnt_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: five-stage pipeline stall/flush controller for memory, multi-cycle, redirect and WFI events.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        loadStall,
    input  logic        EX_redirect,
    input  logic        IM_stall,
    input  logic        DM_stall,
    input  logic        EX_md_start,
    input  logic        EX_md_done,
    input  logic        ID_wfi,
    input  logic        irq_pending,
    output logic        PC_en,
    output logic        IFID_en,
    output logic        IDEX_en,
    output logic        EXMEM_en,
    output logic        MEMWB_en,
    output logic        IFID_flush,
    output logic        IDEX_flush,
    output logic        EXMEM_flush,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);
    import pipeline_ctrl_pkg::*;

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (DM_stall)                          state_d = state_q;
        else if (state_q == MD_WAIT)           state_d = EX_md_done ? RUN : MD_WAIT;
        else if (EX_redirect)                  state_d = IM_stall ? DRAIN : RUN;
        else if (state_q == DRAIN)             state_d = IM_stall ? DRAIN : RUN;
        else if (state_q == WFI)               state_d = irq_pending ? RUN : WFI;
        else if (EX_md_start)                  state_d = MD_WAIT;
        else if (!loadStall && !IM_stall && ID_wfi) state_d = WFI;
    end

    // Flushes keep their enable high so the bubble is actually loaded.
    always_comb begin
        PC_en       = 1'b1;
        IFID_en     = 1'b1;
        IDEX_en     = 1'b1;
        EXMEM_en    = 1'b1;
        MEMWB_en    = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_flush = 1'b0;
        if (!rstn) begin
            {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '0;
            {IFID_flush, IDEX_flush, EXMEM_flush} = '1;
        end else if (DM_stall) begin
            {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '0;
        end else if (state_q == MD_WAIT) begin
            {PC_en, IFID_en, IDEX_en} = '0;
            EXMEM_flush = !EX_md_done;
        end else if (EX_redirect) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (state_q == DRAIN || state_q == WFI) begin
            PC_en      = 1'b0;
            IFID_flush = 1'b1;
        end else if (loadStall) begin
            PC_en      = 1'b0;
            IFID_en    = 1'b0;
            IDEX_flush = 1'b1;
        end else if (IM_stall) begin
            PC_en      = 1'b0;
            IFID_flush = 1'b1;
        end
    end

    assign md_busy = rstn && state_q == MD_WAIT;

    stall_counter u_stall_counter (
        .clk      (clk),
        .rstn     (rstn),
        .en_i     (!PC_en),
        .ld_i     (1'b0),
        .ld_val_i (32'd0),
        .cnt_o    (stall_cnt)
    );
endmodule
